wb_pbus_master: RTL and testbench
=================================

# wb_pbus_master

Parallel-bus-to-Wishbone bridge, the responder-side counterpart of `wb_tube`. An external 8-bit asynchronous host bus (cs_n/rd_n/wr_n strobes, 3-bit address) is synchronised into `clk`. Each host access becomes one Wishbone classic master cycle to a fixed byte window. The block sits as an extra master port in front of the `wb_switch` fabric, giving a host debug and DMA path into the 80186 address space.

## Interface
Parameters:
- BASE, 20'h00080: Wishbone byte address of host register 0; host address adds to it.
- IO_SPACE, 1: value driven on `wb_tga_o` (1 = I/O space, 0 = memory).
- TIMEOUT, 255: clk cycles to wait for `wb_ack_i` before aborting; 8-bit counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pb_adr  in  3  host address, stable while strobe low.
- pb_cs_n  in  1  host chip select, async, active low.
- pb_rd_n  in  1  host read strobe, async, active low.
- pb_wr_n  in  1  host write strobe, async, active low.
- pb_dat_i  in  8  host write data.
- pb_dat_o  out  8  host read data.
- pb_dat_oe  out  1  drive enable for host data pins.
- pb_wait  out  1  high = host must extend the strobe.
- err  out  1  one-cycle pulse on timeout or illegal strobe.
- wb_adr_o  out  19  word address [19:1].
- wb_tga_o  out  1  = IO_SPACE.
- wb_sel_o  out  2  byte lanes.
- wb_dat_o  out  16  write data.
- wb_dat_i  in  16  read data.
- wb_we_o, wb_cyc_o, wb_stb_o  out  1  Wishbone controls.
- wb_ack_i  in  1  Wishbone acknowledge.

## Operation
- cs_n, rd_n and wr_n each pass through a 2-flop synchroniser with reset value 1. Request strobes: `rq_rd = ~cs_s & ~rd_s`, `rq_wr = ~cs_s & ~wr_s`.
- A new access starts only on the transition of a request strobe from 0 to 1. A strobe held through reset is not an access.
- Byte address `A = BASE + pb_adr`, 20-bit modulo. `wb_adr_o = A[19:1]`; `wb_sel_o = A[0] ? 2'b10 : 2'b01`; `wb_dat_o = {pb_dat_i, pb_dat_i}`. `pb_adr` and `pb_dat_i` are captured on the start cycle.
- State machine:
  - IDLE: on rq_wr rise, go to WR_CYC. On rq_rd rise, go to RD_CYC. If both rise or are both active, pulse `err` and go to HOLD with no Wishbone cycle.
  - WR_CYC / RD_CYC: cyc=stb=1; we=1 in WR_CYC only; timeout counter runs. On ack, go to HOLD. For reads, latch lane `A[0] ? wb_dat_i[15:8] : wb_dat_i[7:0]` into `pb_dat_o`. If the counter reaches TIMEOUT without ack, drop cyc/stb, pulse `err`, set `pb_dat_o = 8'hFF` for reads, go to HOLD.
  - HOLD: wait until both request strobes are 0, then go to IDLE.
- `pb_wait` is 1 in WR_CYC and RD_CYC, 0 otherwise.
- `pb_dat_oe` is 1 from RD_CYC entry until HOLD exits, for read accesses only.
- Host deasserting the strobe during WR_CYC/RD_CYC does not cut the Wishbone cycle short; the cycle completes or times out.

## Timing
- Reset values: all outputs 0, except `pb_dat_o = 8'h00`, `wb_tga_o = IO_SPACE`. State IDLE, counter 0.
- Strobe falling at pin → request visible 2 edges later (cycle k) → cyc/stb/adr registered high at k+1. `pb_wait` rises at k+1.
- Host rule: sample `pb_wait` no earlier than 3 clk after asserting the strobe.
- ack high at cycle m → cyc/stb low, `pb_dat_o` valid and `pb_wait` low at m+1. Zero-wait slave: cycle count = 1, total strobe-to-ready = 4 clk.
- No back-to-back cycles: at least one IDLE cycle between accesses.
- Timeout: cyc deasserts TIMEOUT+1 cycles after assertion if no ack. `err` pulses in the same cycle.
- ack arriving in IDLE or HOLD is ignored.
- Reset mid-cycle: cyc/stb/oe/wait are 0 after the next edge; the abandoned Wishbone cycle is not retried.

## Structure
- Package `pbus_pkg`: state enum (IDLE, WR_CYC, RD_CYC, HOLD) and `SEL_LO`/`SEL_HI` constants.
- One sub-module, `pb_sync`: 2-flop synchroniser with reset-to-1 and rise-of-request detect. Instantiated per strobe.
- Remainder is a single FSM plus an 8-bit counter; roughly 180 lines.

## Test plan
- Write pb_adr=3, data 8'h5A, ack after 2 cycles → one cycle with we=1, adr=19'h00041, sel=10, dat=16'h5A5A; `pb_wait` low 4 cycles after ack-request.
- Read pb_adr=2, slave returns 16'hBEEF → sel=01, pb_dat_o=8'hEF, oe high until rd_n releases. Read pb_adr=1 → 8'hBE.
- No ack, TIMEOUT=255 → cyc drops after 256 cycles, err pulses once, pb_dat_o=8'hFF.
- rd_n and wr_n low together → no cyc, err pulse, return to IDLE after both release.
- rst asserted during RD_CYC with strobe still held → outputs idle next edge; no new cycle until strobe releases and re-asserts.
- Back-to-back host writes with strobes separated by 1 clk high → each write produces exactly one Wishbone cycle; none lost or duplicated.

Source files
------------

// File: rtl/pbus_pkg.sv
// Shared types and constants for the host parallel-bus to Wishbone bridge.
package pbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_CYC = 2'd1,
    RD_CYC = 2'd2,
    HOLD   = 2'd3
  } pb_state_e;

  localparam logic [1:0] SEL_LO = 2'b01;
  localparam logic [1:0] SEL_HI = 2'b10;

  // Byte-lane select for a byte address LSB.
  function automatic logic [1:0] lane_sel(input logic a0);
    return a0 ? SEL_HI : SEL_LO;
  endfunction

  // Pick the addressed byte out of a 16-bit Wishbone word.
  function automatic logic [7:0] lane_byte(input logic a0, input logic [15:0] w);
    return a0 ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/pb_sync.sv
// Two-flop synchroniser for chip select plus one host strobe, producing the
// request level and a single-cycle request-rise pulse.
module pb_sync (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  input  logic strb_n,
  output logic rq,
  output logic rq_rise
);

  logic [1:0] cs_q, cs_d;
  logic [1:0] st_q, st_d;
  logic       prev_q, prev_d;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;

  assign rq = ~cs_q[1] & ~st_q[1];
  // A rise only counts once the request has been seen low with pin-derived
  // synchroniser contents, so a strobe held through reset never starts an access.
  assign rq_rise = armed_q & rq & ~prev_q;

  // Next-state for synchroniser chains, edge history and arming.
  always_comb begin
    cs_d    = {cs_q[0], cs_n};
    st_d    = {st_q[0], strb_n};
    prev_d  = rq;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~rq);
  end

  // Synchroniser and detector registers; strobes reset to inactive (1).
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q    <= '1;
      st_q    <= '1;
      prev_q  <= 1'b1;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      cs_q    <= cs_d;
      st_q    <= st_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/wb_pbus_master.sv
// Host 8-bit asynchronous parallel bus to Wishbone classic master bridge.
// Each host read or write becomes one Wishbone cycle into a fixed byte window.
module wb_pbus_master
  import pbus_pkg::*;
#(
  parameter logic [19:0] BASE     = 20'h00080,
  parameter bit          IO_SPACE = 1'b1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  pb_adr,
  input  logic        pb_cs_n,
  input  logic        pb_rd_n,
  input  logic        pb_wr_n,
  input  logic [7:0]  pb_dat_i,
  output logic [7:0]  pb_dat_o,
  output logic        pb_dat_oe,
  output logic        pb_wait,
  output logic        err,
  output logic [19:1] wb_adr_o,
  output logic        wb_tga_o,
  output logic [1:0]  wb_sel_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  logic rq_rd, rq_rd_rise;
  logic rq_wr, rq_wr_rise;

  pb_sync u_sync_rd (
    .clk    (clk),
    .rst    (rst),
    .cs_n   (pb_cs_n),
    .strb_n (pb_rd_n),
    .rq     (rq_rd),
    .rq_rise(rq_rd_rise)
  );

  pb_sync u_sync_wr (
    .clk    (clk),
    .rst    (rst),
    .cs_n   (pb_cs_n),
    .strb_n (pb_wr_n),
    .rq     (rq_wr),
    .rq_rise(rq_wr_rise)
  );

  logic [19:0] byte_adr;
  assign byte_adr = BASE + {17'd0, pb_adr};

  pb_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [19:1] adr_q, adr_d;
  logic        a0_q, a0_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] wdat_q, wdat_d;
  logic [7:0]  rdat_q, rdat_d;
  logic        oe_q, oe_d;
  logic        wait_q, wait_d;
  logic        err_q, err_d;

  // Access sequencing: start on request rise, run one Wishbone cycle, then
  // hold until the host releases both strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    a0_d    = a0_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    oe_d    = oe_q;
    wait_d  = wait_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rq_wr & rq_rd) begin
          err_d   = 1'b1;
          state_d = HOLD;
        end else if (rq_wr_rise | rq_rd_rise) begin
          state_d = rq_wr_rise ? WR_CYC : RD_CYC;
          cyc_d   = 1'b1;
          we_d    = rq_wr_rise;
          adr_d   = byte_adr[19:1];
          a0_d    = byte_adr[0];
          sel_d   = lane_sel(byte_adr[0]);
          wdat_d  = {pb_dat_i, pb_dat_i};
          cnt_d   = '0;
          wait_d  = 1'b1;
          oe_d    = rq_rd_rise;
        end
      end
      WR_CYC, RD_CYC: begin
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          wait_d  = 1'b0;
          state_d = HOLD;
          if (state_q == RD_CYC) rdat_d = lane_byte(a0_q, wb_dat_i);
        end else if (cnt_q == TO_LIM) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          wait_d  = 1'b0;
          err_d   = 1'b1;
          state_d = HOLD;
          if (state_q == RD_CYC) rdat_d = 8'hFF;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (~rq_wr & ~rq_rd) begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      a0_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      oe_q    <= 1'b0;
      wait_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      a0_q    <= a0_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      oe_q    <= oe_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign pb_dat_o  = rdat_q;
  assign pb_dat_oe = oe_q;
  assign pb_wait   = wait_q;
  assign err       = err_q;
  assign wb_adr_o  = adr_q;
  assign wb_tga_o  = IO_SPACE;
  assign wb_sel_o  = sel_q;
  assign wb_dat_o  = wdat_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;

endmodule

// File: tb/tb_wb_pbus_master.sv
// Bench for wb_pbus_master: host-side stimulus, a Wishbone slave responder
// and an address/lane reference model derived from plain arithmetic.
module tb_wb_pbus_master;

  localparam int unsigned BASE_I = 32'h80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  pb_adr = '0;
  logic        pb_cs_n = 1'b1;
  logic        pb_rd_n = 1'b1;
  logic        pb_wr_n = 1'b1;
  logic [7:0]  pb_dat_i = '0;
  logic [7:0]  pb_dat_o;
  logic        pb_dat_oe, pb_wait, err;
  logic [19:1] wb_adr_o;
  logic        wb_tga_o;
  logic [1:0]  wb_sel_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i = '0;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  wb_pbus_master #(.BASE(20'h00080), .IO_SPACE(1'b1), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .pb_adr(pb_adr), .pb_cs_n(pb_cs_n), .pb_rd_n(pb_rd_n),
    .pb_wr_n(pb_wr_n), .pb_dat_i(pb_dat_i), .pb_dat_o(pb_dat_o), .pb_dat_oe(pb_dat_oe),
    .pb_wait(pb_wait), .err(err), .wb_adr_o(wb_adr_o), .wb_tga_o(wb_tga_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  // Slave responder state and transaction log
  bit          ack_en = 1'b1;
  int          ack_delay = 0;
  int          starts = 0, errs = 0, stb_bad = 0, cur_len = 0, last_len = 0;
  bit          cyc_prev = 1'b0;
  logic [18:0] rec_adr [256];
  logic [1:0]  rec_sel [256];
  logic        rec_we  [256];
  logic [15:0] rec_dat [256];

  always @(negedge clk) begin
    if (err === 1'b1) errs++;
    if (wb_stb_o !== wb_cyc_o) stb_bad++;
    if (wb_cyc_o === 1'b1) begin
      if (!cyc_prev) begin
        rec_adr[starts % 256] = wb_adr_o;
        rec_sel[starts % 256] = wb_sel_o;
        rec_we[starts % 256]  = wb_we_o;
        rec_dat[starts % 256] = wb_dat_o;
        starts++;
        cur_len = 0;
      end
      cur_len++;
      wb_ack_i = ack_en && (cur_len - 1 == ack_delay);
    end else begin
      wb_ack_i = 1'b0;
      if (cyc_prev) last_len = cur_len;
    end
    cyc_prev = (wb_cyc_o === 1'b1);
  end

  // Reference model: byte address = BASE + host address (20-bit wrap)
  function automatic int unsigned m_byte(input logic [2:0] a);
    return (BASE_I + a) % (1 << 20);
  endfunction
  function automatic logic [18:0] m_adr(input logic [2:0] a);
    return 19'(m_byte(a) / 2);
  endfunction
  function automatic logic [1:0] m_sel(input logic [2:0] a);
    return (m_byte(a) % 2 == 1) ? 2'b10 : 2'b01;
  endfunction
  function automatic logic [7:0] m_rd(input logic [2:0] a, input logic [15:0] w);
    int unsigned wi;
    wi = w;
    return (m_byte(a) % 2 == 1) ? 8'((wi >> 8) & 255) : 8'(wi & 255);
  endfunction

  // Host access: assert strobe, wait >=3 clk, then until pb_wait falls (bounded)
  task automatic do_access(input bit rd, input logic [2:0] a, input logic [7:0] d,
                           output int lat, output bit wait_seen);
    @(negedge clk);
    pb_adr = a; pb_dat_i = d; pb_cs_n = 1'b0;
    if (rd) pb_rd_n = 1'b0; else pb_wr_n = 1'b0;
    lat = 0; wait_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 3) wait_seen = pb_wait;
    end while (lat < 3 || (pb_wait === 1'b1 && lat < 600));
  endtask

  task automatic release_host();
    pb_cs_n = 1'b1; pb_rd_n = 1'b1; pb_wr_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, pb_wait, pb_dat_oe, err} !== 6'b0)
      $display("FAIL reset_ctrl got %b want 000000", {wb_cyc_o, wb_stb_o, wb_we_o, pb_wait, pb_dat_oe, err});
    else n_pass++;
    n_checks++;
    if (pb_dat_o !== 8'h00) $display("FAIL reset_pb_dat_o got %h want 00", pb_dat_o);
    else n_pass++;
    n_checks++;
    if (wb_tga_o !== 1'b1) $display("FAIL reset_tga got %b want 1", wb_tga_o);
    else n_pass++;
    n_checks++;
    if ({wb_adr_o, wb_sel_o, wb_dat_o} !== 37'd0)
      $display("FAIL reset_wb_bus got %h/%b/%h want 0", wb_adr_o, wb_sel_o, wb_dat_o);
    else n_pass++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write();
    int lat, s0;
    bit ws;
    s0 = starts; ack_delay = 2; ack_en = 1'b1;
    do_access(1'b0, 3'd3, 8'h5A, lat, ws);
    n_checks++;
    if (lat !== 6 || !ws) $display("FAIL wr_latency got %0d wait_seen=%0d want 6 1", lat, ws);
    else n_pass++;
    release_host();
    @(negedge clk);
    n_checks++;
    if (starts - s0 !== 1) $display("FAIL wr_cycles got %0d want 1", starts - s0);
    else n_pass++;
    n_checks++;
    if ({rec_adr[s0 % 256], rec_sel[s0 % 256], rec_we[s0 % 256], rec_dat[s0 % 256]} !==
        {19'h00041, 2'b10, 1'b1, 16'h5A5A})
      $display("FAIL wr_fields got adr=%h sel=%b we=%b dat=%h want 00041 10 1 5a5a",
               rec_adr[s0 % 256], rec_sel[s0 % 256], rec_we[s0 % 256], rec_dat[s0 % 256]);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read();
    int lat, s0;
    bit ws;
    ack_delay = 0; wb_dat_i = 16'hBEEF; s0 = starts;
    do_access(1'b1, 3'd2, 8'h00, lat, ws);
    n_checks++;
    if (lat !== 4 || !ws) $display("FAIL rd_latency got %0d wait_seen=%0d want 4 1", lat, ws);
    else n_pass++;
    n_checks++;
    if (pb_dat_o !== 8'hEF || pb_dat_oe !== 1'b1)
      $display("FAIL rd2_data got %h oe=%b want ef 1", pb_dat_o, pb_dat_oe);
    else n_pass++;
    release_host();
    @(negedge clk);
    n_checks++;
    if (rec_sel[s0 % 256] !== 2'b01 || rec_we[s0 % 256] !== 1'b0)
      $display("FAIL rd2_sel got sel=%b we=%b want 01 0", rec_sel[s0 % 256], rec_we[s0 % 256]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (pb_dat_oe !== 1'b1) $display("FAIL rd_oe_hold got %b want 1", pb_dat_oe);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (pb_dat_oe !== 1'b0) $display("FAIL rd_oe_drop got %b want 0", pb_dat_oe);
    else n_pass++;
    repeat (2) @(negedge clk);
    do_access(1'b1, 3'd1, 8'h00, lat, ws);
    n_checks++;
    if (pb_dat_o !== 8'hBE) $display("FAIL rd1_data got %h want be", pb_dat_o);
    else n_pass++;
    release_host();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat, s0, e0;
    bit ws;
    ack_en = 1'b0; s0 = starts; e0 = errs;
    do_access(1'b1, 3'd5, 8'h00, lat, ws);
    n_checks++;
    if (lat !== 259) $display("FAIL to_latency got %0d want 259", lat);
    else n_pass++;
    n_checks++;
    if (pb_dat_o !== 8'hFF) $display("FAIL to_data got %h want ff", pb_dat_o);
    else n_pass++;
    release_host();
    @(negedge clk);
    n_checks++;
    if (last_len !== 256 || starts - s0 !== 1)
      $display("FAIL to_cyc_len got %0d cycles=%0d want 256 1", last_len, starts - s0);
    else n_pass++;
    n_checks++;
    if (errs - e0 !== 1) $display("FAIL to_err_pulses got %0d want 1", errs - e0);
    else n_pass++;
    ack_en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_illegal();
    int lat, s0, e0;
    bit ws, wait_hi;
    s0 = starts; e0 = errs; wait_hi = 1'b0;
    @(negedge clk);
    pb_cs_n = 1'b0; pb_rd_n = 1'b0; pb_wr_n = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (pb_wait === 1'b1) wait_hi = 1'b1;
    end
    n_checks++;
    if (starts - s0 !== 0 || wait_hi) $display("FAIL ill_no_cycle got %0d wait=%0d want 0 0", starts - s0, wait_hi);
    else n_pass++;
    n_checks++;
    if (errs - e0 !== 1) $display("FAIL ill_err got %0d want 1", errs - e0);
    else n_pass++;
    release_host();
    repeat (4) @(negedge clk);
    ack_delay = 1;
    do_access(1'b0, 3'd0, 8'h11, lat, ws);
    release_host();
    @(negedge clk);
    n_checks++;
    if (starts - s0 !== 1 || rec_adr[s0 % 256] !== m_adr(3'd0) || rec_dat[s0 % 256] !== 16'h1111)
      $display("FAIL ill_recover got cycles=%0d adr=%h dat=%h want 1 %h 1111",
               starts - s0, rec_adr[s0 % 256], rec_dat[s0 % 256], m_adr(3'd0));
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, s0;
    bit ws;
    ack_en = 1'b0; s0 = starts;
    @(negedge clk);
    pb_adr = 3'd4; pb_cs_n = 1'b0; pb_rd_n = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (wb_cyc_o !== 1'b1) $display("FAIL rmid_in_cycle got %b want 1", wb_cyc_o);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, pb_dat_oe, pb_wait} !== 4'b0)
      $display("FAIL rmid_idle got %b want 0000", {wb_cyc_o, wb_stb_o, pb_dat_oe, pb_wait});
    else n_pass++;
    rst = 1'b0;
    ack_en = 1'b1; ack_delay = 0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (starts - s0 !== 1) $display("FAIL rmid_no_retry got %0d want 1", starts - s0);
    else n_pass++;
    release_host();
    repeat (4) @(negedge clk);
    wb_dat_i = 16'h1234;
    do_access(1'b1, 3'd4, 8'h00, lat, ws);
    n_checks++;
    if (pb_dat_o !== m_rd(3'd4, 16'h1234) || lat !== 4)
      $display("FAIL rmid_reaccess got %h lat=%0d want %h 4", pb_dat_o, lat, m_rd(3'd4, 16'h1234));
    else n_pass++;
    release_host();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, s0;
    bit ws;
    logic [2:0] a1, a2;
    logic [7:0] d1, d2;
    a1 = 3'($urandom_range(0, 7)); a2 = 3'($urandom_range(0, 7));
    d1 = 8'($urandom); d2 = 8'($urandom);
    ack_delay = 1; s0 = starts;
    do_access(1'b0, a1, d1, lat1, ws);
    release_host();
    do_access(1'b0, a2, d2, lat2, ws);
    release_host();
    @(negedge clk);
    n_checks++;
    if (starts - s0 !== 2 || lat2 !== 5) $display("FAIL b2b_count got %0d lat=%0d want 2 5", starts - s0, lat2);
    else n_pass++;
    n_checks++;
    if (rec_adr[s0 % 256] !== m_adr(a1) || rec_dat[s0 % 256] !== {d1, d1} ||
        rec_adr[(s0 + 1) % 256] !== m_adr(a2) || rec_dat[(s0 + 1) % 256] !== {d2, d2})
      $display("FAIL b2b_fields got %h/%h %h/%h want %h/%h %h/%h",
               rec_adr[s0 % 256], rec_dat[s0 % 256], rec_adr[(s0 + 1) % 256], rec_dat[(s0 + 1) % 256],
               m_adr(a1), {d1, d1}, m_adr(a2), {d2, d2});
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    int lat, s0, dly;
    bit ws, rd;
    logic [2:0] a;
    logic [7:0] d;
    logic [15:0] w;
    for (int i = 0; i < 16; i++) begin
      rd = 1'($urandom); a = 3'($urandom); d = 8'($urandom); w = 16'($urandom);
      dly = int'($urandom_range(0, 4));
      ack_delay = dly; wb_dat_i = w; s0 = starts;
      do_access(rd, a, d, lat, ws);
      n_checks++;
      if (lat !== 4 + dly || (rd && pb_dat_o !== m_rd(a, w)))
        $display("FAIL rand%0d_resp got lat=%0d dat=%h want %0d %h", i, lat, pb_dat_o, 4 + dly, m_rd(a, w));
      else n_pass++;
      release_host();
      @(negedge clk);
      n_checks++;
      if (starts - s0 !== 1 || rec_adr[s0 % 256] !== m_adr(a) || rec_sel[s0 % 256] !== m_sel(a) ||
          rec_we[s0 % 256] !== !rd || (!rd && rec_dat[s0 % 256] !== {d, d}))
        $display("FAIL rand%0d_cycle got n=%0d adr=%h sel=%b we=%b dat=%h want 1 %h %b %b %h", i,
                 starts - s0, rec_adr[s0 % 256], rec_sel[s0 % 256], rec_we[s0 % 256], rec_dat[s0 % 256],
                 m_adr(a), m_sel(a), !rd, {d, d});
      else n_pass++;
      repeat (3) @(negedge clk);
    end
    n_checks++;
    if (stb_bad !== 0) $display("FAIL stb_eq_cyc got %0d mismatched samples want 0", stb_bad);
    else n_pass++;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
